peak_bank_select: RTL and testbench

- Upstream stage of the bank-to-LED colour mapper in the audio visualiser.
- Accepts one frame of 16 filter-bank energy samples, streamed in bank order 0..15, and finds the loudest bank.
- Applies an energy threshold and frame-persistence hysteresis, then drives a registered 5-bit best-bank index.
- Index 16 means "no bank active"; the colour mapper renders it as black.

---
 rtl/peak_bank_select.sv | 92 +++++++++
 tb/tb_peak_bank_select.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/peak_bank_select.sv
// peak_bank_select: finds the loudest of 16 filter-bank energies per frame,
// gates it with an energy threshold and frame-persistence hysteresis, and
// presents a registered best-bank index (16 = no bank active).
module peak_bank_select #(
    parameter int EW     = 16,
    parameter int NBANKS = 16,
    parameter int THRESH = 256,
    parameter int HOLD   = 3
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          frame_sync,
    input  logic          energy_valid,
    input  logic [EW-1:0] energy_data,
    output logic [4:0]    best_bank,
    output logic [EW-1:0] best_energy,
    output logic          best_valid,
    output logic          frame_err
);

    localparam logic [3:0]    LAST_IDX = 4'(NBANKS - 1);
    localparam logic [EW-1:0] THRESH_V = EW'(THRESH);
    localparam logic [3:0]    HOLD_V   = 4'(HOLD);
    localparam logic [4:0]    NONE     = 5'd16;

    logic [3:0]    cnt_q;
    logic [EW-1:0] max_q;
    logic [3:0]    arg_q;
    logic [3:0]    hold_q;
    logic [4:0]    pend_q;

    logic [3:0]    idx;
    logic          take;
    logic [EW-1:0] fmax;
    logic [3:0]    farg;
    logic [4:0]    cand;
    logic [3:0]    hold_nx;

    // Running max including the current sample; frame_sync makes it index 0.
    always_comb begin
        idx     = frame_sync ? 4'd0 : cnt_q;
        take    = (idx == 4'd0) || (energy_data > max_q);
        fmax    = take ? energy_data : max_q;
        farg    = take ? idx : arg_q;
        cand    = (fmax >= THRESH_V) ? {1'b0, farg} : NONE;
        hold_nx = (cand == pend_q) ? hold_q + 4'd1 : 4'd1;
    end

    // Scan counter, running max/arg, commit and hysteresis state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q       <= '0;
            max_q       <= '0;
            arg_q       <= '0;
            hold_q      <= '0;
            pend_q      <= NONE;
            best_bank   <= NONE;
            best_energy <= '0;
            best_valid  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            best_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (frame_sync && (cnt_q != 4'd0)) begin
                frame_err <= 1'b1;
            end
            if (energy_valid) begin
                cnt_q <= idx + 4'd1;
                max_q <= fmax;
                arg_q <= farg;
                if (idx == LAST_IDX) begin
                    best_valid  <= 1'b1;
                    best_energy <= fmax;
                    if (cand == best_bank) begin
                        hold_q <= '0;
                    end else begin
                        pend_q <= cand;
                        if (hold_nx >= HOLD_V) begin
                            best_bank <= cand;
                            hold_q    <= '0;
                        end else begin
                            hold_q <= hold_nx;
                        end
                    end
                end
            end else if (frame_sync) begin
                cnt_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_peak_bank_select.sv
// Bench for peak_bank_select: two instances (HOLD=1 and HOLD=3) share the
// stimulus; expected commits are queued when a frame's last sample is driven
// and popped when best_valid appears.
module tb_peak_bank_select;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        frame_sync;
    logic        energy_valid;
    logic [15:0] energy_data;

    logic [4:0]  bank1, bank3;
    logic [15:0] en1, en3;
    logic        val1, val3, ferr1, ferr3;

    peak_bank_select #(.EW(16), .NBANKS(16), .THRESH(256), .HOLD(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .frame_sync(frame_sync),
        .energy_valid(energy_valid), .energy_data(energy_data),
        .best_bank(bank1), .best_energy(en1), .best_valid(val1), .frame_err(ferr1)
    );

    peak_bank_select #(.EW(16), .NBANKS(16), .THRESH(256), .HOLD(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .frame_sync(frame_sync),
        .energy_valid(energy_valid), .energy_data(energy_data),
        .best_bank(bank3), .best_energy(en3), .best_valid(val3), .frame_err(ferr3)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] base;
        logic [15:0] step;
        int          pk0;
        int          pk1;
        logic [15:0] pkv;
        logic [4:0]  b1;
        logic [4:0]  b3;
        logic [15:0] e;
    } vec_t;

    typedef struct {
        logic [4:0]  b1;
        logic [4:0]  b3;
        logic [15:0] e;
    } exp_t;

    vec_t tbl[15];
    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   n_ferr = 0;
    int   n_commit = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic logic [15:0] energy_of(input vec_t v, input int i);
        if (i == v.pk0 || i == v.pk1) return v.pkv;
        return v.base + v.step * 16'(i);
    endfunction

    // Pops the scoreboard whenever a commit is observed.
    task automatic monitor();
        exp_t x;
        chk("valid_match", {31'd0, val3}, {31'd0, val1});
        if (ferr1) n_ferr++;
        chk("ferr_match", {31'd0, ferr3}, {31'd0, ferr1});
        if (val1) begin
            n_commit++;
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_commit: got best_valid=1, expected 0");
            end else begin
                x = sb.pop_front();
                chk("best_bank_h1", {27'd0, bank1}, {27'd0, x.b1});
                chk("best_bank_h3", {27'd0, bank3}, {27'd0, x.b3});
                chk("best_energy_h1", {16'd0, en1}, {16'd0, x.e});
                chk("best_energy_h3", {16'd0, en3}, {16'd0, x.e});
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        monitor();
    endtask

    task automatic drive_frame(input vec_t v, input bit gaps, input bit sync0);
        exp_t x;
        for (int i = 0; i < 16; i++) begin
            energy_valid = 1'b1;
            energy_data  = energy_of(v, i);
            frame_sync   = (i == 0) ? sync0 : 1'b0;
            if (i == 15) begin
                x.b1 = v.b1;
                x.b3 = v.b3;
                x.e  = v.e;
                sb.push_back(x);
            end
            tick();
            frame_sync = 1'b0;
            if (i == 0) chk("frame_err", {31'd0, ferr1}, {31'd0, sync0});
            if (i < 15) chk("no_early_commit", {31'd0, val1}, 32'd0);
            if (i == 15) chk("commit_latency", {31'd0, val1}, 32'd1);
            if (gaps && (i % 4 == 1)) begin
                energy_valid = 1'b0;
                tick();
            end
        end
    endtask

    task automatic chk_reset_values();
        chk("rst_bank_h1", {27'd0, bank1}, 32'd16);
        chk("rst_bank_h3", {27'd0, bank3}, 32'd16);
        chk("rst_energy", {16'd0, en1}, 32'd0);
        chk("rst_valid", {31'd0, val1}, 32'd0);
        chk("rst_err", {31'd0, ferr1}, 32'd0);
    endtask

    initial begin
        vec_t v;
        //          base  step  pk0 pk1  pkv    b1     b3     e
        tbl[0]  = '{16'd100, 16'd100, -1, -1, 16'd0,    5'd15, 5'd16, 16'd1600};
        tbl[1]  = '{16'd10,  16'd0,    3,  9, 16'd5000, 5'd3,  5'd16, 16'd5000};
        tbl[2]  = '{16'd200, 16'd0,   -1, -1, 16'd0,    5'd16, 5'd16, 16'd200};
        tbl[3]  = '{16'd256, 16'd0,   -1, -1, 16'd0,    5'd0,  5'd16, 16'd256};
        tbl[4]  = '{16'd50,  16'd0,    4,  4, 16'd3000, 5'd4,  5'd16, 16'd3000};
        tbl[5]  = '{16'd50,  16'd0,    4,  4, 16'd3000, 5'd4,  5'd16, 16'd3000};
        tbl[6]  = '{16'd50,  16'd0,    4,  4, 16'd3000, 5'd4,  5'd4,  16'd3000};
        tbl[7]  = '{16'd50,  16'd0,    7,  7, 16'd3000, 5'd7,  5'd4,  16'd3000};
        tbl[8]  = '{16'd50,  16'd0,    7,  7, 16'd3000, 5'd7,  5'd4,  16'd3000};
        tbl[9]  = '{16'd50,  16'd0,    5,  5, 16'd3000, 5'd5,  5'd4,  16'd3000};
        tbl[10] = '{16'd50,  16'd0,    7,  7, 16'd3000, 5'd7,  5'd4,  16'd3000};
        tbl[11] = '{16'd50,  16'd0,    7,  7, 16'd3000, 5'd7,  5'd4,  16'd3000};
        tbl[12] = '{16'd50,  16'd0,    7,  7, 16'd3000, 5'd7,  5'd7,  16'd3000};
        tbl[13] = '{16'd20,  16'd1,    0,  0, 16'd900,  5'd0,  5'd7,  16'd900};
        tbl[14] = '{16'd255, 16'd0,   -1, -1, 16'd0,    5'd16, 5'd7,  16'd255};

        reset_n      = 1'b0;
        frame_sync   = 1'b0;
        energy_valid = 1'b0;
        energy_data  = '0;
        tick();
        tick();
        chk_reset_values();
        reset_n = 1'b1;
        tick();

        // Frames back to back: the cycle after sample 15 carries the next index 0.
        for (int r = 0; r < 15; r++) begin
            drive_frame(tbl[r], (r % 2) == 1, 1'b0);
        end
        energy_valid = 1'b0;
        tick();
        chk("valid_one_cycle", {31'd0, val1}, 32'd0);
        tick();

        // Abort after 6 loud samples; sync coincides with the new frame's index 0.
        for (int i = 0; i < 6; i++) begin
            energy_valid = 1'b1;
            energy_data  = 16'd60000;
            tick();
        end
        v = '{16'd30, 16'd0, 11, 11, 16'd2000, 5'd11, 5'd7, 16'd2000};
        drive_frame(v, 1'b1, 1'b1);
        energy_valid = 1'b0;
        tick();
        tick();

        // frame_sync with the counter already at 0 must not flag an error.
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        chk("sync_noop_err", {31'd0, ferr1}, 32'd0);
        tick();

        // Reset after 9 samples discards the partial frame.
        for (int i = 0; i < 9; i++) begin
            energy_valid = 1'b1;
            energy_data  = 16'd50000;
            tick();
        end
        energy_valid = 1'b0;
        reset_n      = 1'b0;
        tick();
        chk_reset_values();
        reset_n = 1'b1;
        v = '{16'd40, 16'd0, 2, 2, 16'd4000, 5'd2, 5'd16, 16'd4000};
        drive_frame(v, 1'b0, 1'b0);
        energy_valid = 1'b0;
        tick();
        tick();

        chk("sb_drained", sb.size(), 32'd0);
        chk("commit_count", n_commit, 32'd17);
        chk("frame_err_count", n_ferr, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
